// File: rtl/digital_clock_counter.sv
// Time-of-day counter: divides clk to a 1 Hz enable and keeps a 24-hour HH:MM:SS count
// as split BCD digits, with a validated parallel load and a run/pause control.
// Optional feature: define ALARM_EN to add the HH:MM alarm ports and compare logic.
module digital_clock_counter #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [2:0] ld_seconds_p1,
  input  logic [3:0] ld_seconds_p2,
  input  logic [2:0] ld_minutes_p1,
  input  logic [3:0] ld_minutes_p2,
  input  logic [1:0] ld_hours_p1,
  input  logic [3:0] ld_hours_p2,
  output logic [2:0] seconds_p1,
  output logic [3:0] seconds_p2,
  output logic [2:0] minutes_p1,
  output logic [3:0] minutes_p2,
  output logic [1:0] hours_p1,
  output logic [3:0] hours_p2,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
`ifdef ALARM_EN
  ,
  input  logic [1:0] alarm_hours_p1,
  input  logic [3:0] alarm_hours_p2,
  input  logic [2:0] alarm_minutes_p1,
  input  logic [3:0] alarm_minutes_p2,
  input  logic [0:0] alarm_arm,
  output logic       alarm
`endif
);

  localparam int unsigned PresW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PresW-1:0] PresTc = PresW'(CLK_DIV - 1);

  // State registers
  logic [PresW-1:0] r_presc;
  logic [2:0]       r_sec_p1;
  logic [3:0]       r_sec_p2;
  logic [2:0]       r_min_p1;
  logic [3:0]       r_min_p2;
  logic [1:0]       r_hr_p1;
  logic [3:0]       r_hr_p2;
  logic             r_sec_tick;
  logic             r_day_wrap;
  logic             r_load_err;

  // Next-state values
  logic [PresW-1:0] w_presc_nxt;
  logic [2:0]       w_sec_p1_nxt;
  logic [3:0]       w_sec_p2_nxt;
  logic [2:0]       w_min_p1_nxt;
  logic [3:0]       w_min_p2_nxt;
  logic [1:0]       w_hr_p1_nxt;
  logic [3:0]       w_hr_p2_nxt;

  // Time after one increment
  logic [2:0]       w_inc_sec_p1;
  logic [3:0]       w_inc_sec_p2;
  logic [2:0]       w_inc_min_p1;
  logic [3:0]       w_inc_min_p2;
  logic [1:0]       w_inc_hr_p1;
  logic [3:0]       w_inc_hr_p2;

  logic w_tc;
  logic w_ld_valid;
  logic w_load_ok;
  logic w_load_bad;
  logic w_tick;
  logic w_wrap;
  logic w_c_sec_p2;
  logic w_c_sec_p1;
  logic w_c_min_p2;
  logic w_c_min_p1;

  // Terminal count and load qualification
  always_comb begin
    w_tc       = run && (r_presc == PresTc);
    w_ld_valid = (ld_seconds_p1 <= 3'd5) && (ld_seconds_p2 <= 4'd9) &&
                 (ld_minutes_p1 <= 3'd5) && (ld_minutes_p2 <= 4'd9) &&
                 (ld_hours_p1 <= 2'd2)   && (ld_hours_p2 <= 4'd9) &&
                 !((ld_hours_p1 == 2'd2) && (ld_hours_p2 > 4'd3));
    w_load_ok  = load && w_ld_valid;
    w_load_bad = load && !w_ld_valid;
    // A valid load in the terminal-count cycle swallows that tick
    w_tick     = w_tc && !w_load_ok;
  end

  // Cascaded BCD increment of the current time
  always_comb begin
    w_c_sec_p2   = (r_sec_p2 == 4'd9);
    w_c_sec_p1   = w_c_sec_p2 && (r_sec_p1 == 3'd5);
    w_c_min_p2   = w_c_sec_p1 && (r_min_p2 == 4'd9);
    w_c_min_p1   = w_c_min_p2 && (r_min_p1 == 3'd5);
    w_wrap       = w_c_min_p1 && (r_hr_p1 == 2'd2) && (r_hr_p2 == 4'd3);

    w_inc_sec_p2 = w_c_sec_p2 ? 4'd0 : r_sec_p2 + 4'd1;
    w_inc_sec_p1 = r_sec_p1;
    if (w_c_sec_p2) w_inc_sec_p1 = (r_sec_p1 == 3'd5) ? 3'd0 : r_sec_p1 + 3'd1;
    w_inc_min_p2 = r_min_p2;
    if (w_c_sec_p1) w_inc_min_p2 = (r_min_p2 == 4'd9) ? 4'd0 : r_min_p2 + 4'd1;
    w_inc_min_p1 = r_min_p1;
    if (w_c_min_p2) w_inc_min_p1 = (r_min_p1 == 3'd5) ? 3'd0 : r_min_p1 + 3'd1;

    w_inc_hr_p1  = r_hr_p1;
    w_inc_hr_p2  = r_hr_p2;
    if (w_c_min_p1) begin
      if (w_wrap) begin
        w_inc_hr_p1 = 2'd0;
        w_inc_hr_p2 = 4'd0;
      end else if (r_hr_p2 == 4'd9) begin
        w_inc_hr_p1 = r_hr_p1 + 2'd1;
        w_inc_hr_p2 = 4'd0;
      end else begin
        w_inc_hr_p2 = r_hr_p2 + 4'd1;
      end
    end
  end

  // Next prescaler and time: load beats tick, tick beats hold
  always_comb begin
    w_presc_nxt  = r_presc;
    w_sec_p1_nxt = r_sec_p1;
    w_sec_p2_nxt = r_sec_p2;
    w_min_p1_nxt = r_min_p1;
    w_min_p2_nxt = r_min_p2;
    w_hr_p1_nxt  = r_hr_p1;
    w_hr_p2_nxt  = r_hr_p2;

    if (!run || w_tc) w_presc_nxt = '0;
    else              w_presc_nxt = r_presc + PresW'(1);

    if (w_load_ok) begin
      w_presc_nxt  = '0;
      w_sec_p1_nxt = ld_seconds_p1;
      w_sec_p2_nxt = ld_seconds_p2;
      w_min_p1_nxt = ld_minutes_p1;
      w_min_p2_nxt = ld_minutes_p2;
      w_hr_p1_nxt  = ld_hours_p1;
      w_hr_p2_nxt  = ld_hours_p2;
    end else if (w_tick) begin
      w_sec_p1_nxt = w_inc_sec_p1;
      w_sec_p2_nxt = w_inc_sec_p2;
      w_min_p1_nxt = w_inc_min_p1;
      w_min_p2_nxt = w_inc_min_p2;
      w_hr_p1_nxt  = w_inc_hr_p1;
      w_hr_p2_nxt  = w_inc_hr_p2;
    end
  end

  // State and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_sec_p1   <= 3'd0;
      r_sec_p2   <= 4'd0;
      r_min_p1   <= 3'd0;
      r_min_p2   <= 4'd0;
      r_hr_p1    <= 2'd0;
      r_hr_p2    <= 4'd0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_sec_p1   <= w_sec_p1_nxt;
      r_sec_p2   <= w_sec_p2_nxt;
      r_min_p1   <= w_min_p1_nxt;
      r_min_p2   <= w_min_p2_nxt;
      r_hr_p1    <= w_hr_p1_nxt;
      r_hr_p2    <= w_hr_p2_nxt;
      r_sec_tick <= w_tick;
      r_day_wrap <= w_tick && w_wrap;
      r_load_err <= w_load_bad;
    end
  end

  assign seconds_p1 = r_sec_p1;
  assign seconds_p2 = r_sec_p2;
  assign minutes_p1 = r_min_p1;
  assign minutes_p2 = r_min_p2;
  assign hours_p1   = r_hr_p1;
  assign hours_p2   = r_hr_p2;
  assign sec_tick   = r_sec_tick;
  assign day_wrap   = r_day_wrap;
  assign load_err   = r_load_err;

`ifdef ALARM_EN
  logic r_alarm;
  logic w_alarm_hit;

  // Fires only on an increment that lands on HH:MM:00 of the armed alarm time
  always_comb begin
    w_alarm_hit = alarm_arm[0] && w_tick &&
                  (w_inc_sec_p1 == 3'd0) && (w_inc_sec_p2 == 4'd0) &&
                  (w_inc_min_p1 == alarm_minutes_p1) && (w_inc_min_p2 == alarm_minutes_p2) &&
                  (w_inc_hr_p1 == alarm_hours_p1) && (w_inc_hr_p2 == alarm_hours_p2);
  end

  // Alarm pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alarm <= 1'b0;
    else        r_alarm <= w_alarm_hit;
  end

  assign alarm = r_alarm;
`endif

endmodule

// File: doc/digital_clock_counter.md
Name: digital_clock_counter

Overview:
Time-of-day source for the seven-segment display path. Divides the system clock down to a 1 Hz enable and keeps a 24-hour HH:MM:SS count as split BCD digits. The six digit outputs connect directly to the display decoder's digit inputs. Supports a validated parallel load for setting the time and an enable for pausing.

Parameters:
CLK_DIV, 50000000, clk cycles per second. Legal range is 2 or more. Prescaler width is $clog2(CLK_DIV).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = count; 0 = hold time and clear prescaler
load  input  1  single-cycle request to load the ld_* fields
ld_seconds_p1  input  3  seconds tens digit to load
ld_seconds_p2  input  4  seconds ones digit to load
ld_minutes_p1  input  3  minutes tens digit to load
ld_minutes_p2  input  4  minutes ones digit to load
ld_hours_p1  input  2  hours tens digit to load
ld_hours_p2  input  4  hours ones digit to load
seconds_p1  output  3  seconds tens digit, range 0-5
seconds_p2  output  4  seconds ones digit, range 0-9
minutes_p1  output  3  minutes tens digit, range 0-5
minutes_p2  output  4  minutes ones digit, range 0-9
hours_p1  output  2  hours tens digit, range 0-2
hours_p2  output  4  hours ones digit, range 0-9 (0-3 when hours_p1 = 2)
sec_tick  output  1  one-cycle pulse when the time advances
day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-low on rst_n.
- Reset values: all digit outputs = 0 (00:00:00). Prescaler = 0. sec_tick, day_wrap and load_err = 0.
- All outputs are registered.
- Prescaler:
  - While run = 1, counts 0 .. CLK_DIV-1 and then wraps to 0.
  - On the edge where the prescaler equals CLK_DIV-1, the time increments and sec_tick = 1 for the following cycle.
  - First tick occurs CLK_DIV cycles after run rises.
  - run = 0: prescaler is forced to 0, time holds, no ticks.
- Increment is a cascaded BCD ripple:
  - seconds_p2 9 -> 0 carries into seconds_p1; seconds_p1 5 -> 0 carries into minutes_p2.
  - Minutes use the same rule and carry into the hours.
  - hours_p2 9 -> 0 with hours_p1 +1.
  - At 23:59:59 all digits go to 0 and day_wrap = 1 in the same cycle as sec_tick.
- Load validation:
  - A load is valid when: seconds_p1 ≤ 5, seconds_p2 ≤ 9, minutes_p1 ≤ 5, minutes_p2 ≤ 9, hours_p1 ≤ 2, hours_p2 ≤ 9, and hours_p2 ≤ 3 when hours_p1 = 2.
  - Valid load: digits take the ld_* values on the next edge and the prescaler clears to 0. No sec_tick is generated by the load.
  - Invalid load: time and prescaler are unchanged, and load_err = 1 for one cycle.
  - Loads are accepted regardless of run.
- Simultaneous events:
  - Load and a prescaler terminal count in the same cycle: load wins and the tick is dropped (sec_tick = 0).
  - Invalid load plus terminal count: the tick proceeds normally and load_err = 1.
- Reset mid-count: asynchronous return to 00:00:00 and prescaler 0. Pulses deassert immediately.
- Digit outputs never hold out-of-range codes.

Optional Feature:
Macro ALARM_EN.
- Defined: adds these ports.
  - Inputs alarm_hours_p1[1:0], alarm_hours_p2[3:0], alarm_minutes_p1[2:0], alarm_minutes_p2[3:0] and alarm_arm[0:0].
  - Output alarm (1 bit, reset 0).
- Defined, behaviour: alarm pulses for one cycle, coincident with sec_tick, when an increment produces HH:MM:00 equal to the alarm fields while alarm_arm = 1. A load reaching the matching time does not fire the alarm.
- Not defined: no alarm ports or logic exist.

Test Plan:
- CLK_DIV=4, reset, then run = 1 -> first sec_tick 4 cycles later, seconds_p2 = 1. After 40 cycles the time is 00:00:10 (seconds_p1 = 1, seconds_p2 = 0).
- Load 23:59:58 with run = 1 -> after 2 ticks the time is 00:00:00, day_wrap pulses once with the second tick, all digits = 0.
- Load 24:00:00, then 12:60:00, then 09:0A:00 -> load_err pulses each time and the time is unchanged.
- Load 09:59:59 asserted in the prescaler's terminal-count cycle -> time = 09:59:59, no sec_tick, next tick exactly 4 cycles later gives 10:00:00.
- run = 0 for 20 cycles at 01:02:03 -> time holds and no sec_tick. Then run = 1 -> next tick after 4 cycles. rst_n low mid-count -> outputs are 0 immediately.
- ALARM_EN with alarm 07:30 armed, load 07:29:59 -> alarm pulses with the next tick. Disarmed -> no pulse.
